// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among four byte requesters. A round-robin
// pick in IDLE latches the winner's byte and frame format, the frame is
// launched once the transmitter is free, completion (or a timeout) is
// awaited, and an idle gap is inserted before the next grant.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | sampling req; grants the next requester in rr order
// S_LAUNCH    | byte latched; waiting for tx_busy low to pulse tx_start
// S_WAIT_DONE | frame in flight; timeout counter running
// S_GAP       | inter-frame idle gap of GAP_CYC cycles
//
// TIMEOUT must not exceed 8191: the frame timer is 13 bits wide.

module uart_tx_arbiter #(
    parameter int GAP_CYC = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk_tx,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_d_num,
    input  logic [3:0]  req_stop_bits,
    output logic [3:0]  gnt,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        tx_d_num,
    output logic        tx_stop_bits,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic [1:0]  active_id,
    output logic        err_timeout
);

    localparam int               GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [12:0]      TO_LAST  = 13'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       rr_ptr;
    logic [1:0]       rr_nxt;
    logic [12:0]      to_cnt;
    logic [12:0]      to_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_nxt;

    logic [3:0]       gnt_nxt;
    logic             tx_start_nxt;
    logic [7:0]       tx_data_nxt;
    logic             tx_d_num_nxt;
    logic             tx_stop_nxt;
    logic [1:0]       active_id_nxt;
    logic             err_nxt;

    logic             req_any;
    logic [1:0]       win_id;
    logic [1:0]       cand;
    logic [7:0]       win_byte;
    logic             win_d_num;
    logic             win_stop;

    // After a frame ends, the FSM either idles for the gap or, with no gap
    // configured, returns straight to IDLE so the next edge samples req.
    function automatic state_t post_frame_state();
        return (GAP_CYC == 0) ? S_IDLE : S_GAP;
    endfunction

    assign req_any = |req;

    // Round-robin pick: first set req bit at or above rr_ptr, wrapping 3->0.
    // Scanning offsets from high to low lets the lowest offset win.
    always_comb begin
        win_id = rr_ptr;
        cand   = '0;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_ptr + 2'(i);
            if (req[cand]) begin
                win_id = cand;
            end
        end
    end

    // Winner's frame fields; 7-bit frames never carry a stray bit 7.
    always_comb begin
        win_byte  = req_data[{win_id, 3'b000} +: 8];
        win_d_num = req_d_num[win_id];
        win_stop  = req_stop_bits[win_id];
        if (!win_d_num) begin
            win_byte[7] = 1'b0;
        end
    end

    // Next-state and next-output decode; pulses default low, holds default to current.
    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        to_cnt_nxt    = to_cnt;
        gap_cnt_nxt   = gap_cnt;
        gnt_nxt       = '0;
        tx_start_nxt  = 1'b0;
        err_nxt       = 1'b0;
        tx_data_nxt   = tx_data;
        tx_d_num_nxt  = tx_d_num;
        tx_stop_nxt   = tx_stop_bits;
        active_id_nxt = active_id;

        case (state)
            S_IDLE: begin
                if (req_any) begin
                    gnt_nxt[win_id] = 1'b1;
                    tx_data_nxt     = win_byte;
                    tx_d_num_nxt    = win_d_num;
                    tx_stop_nxt     = win_stop;
                    active_id_nxt   = win_id;
                    rr_nxt          = win_id + 2'd1;
                    state_nxt       = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                // No timeout here: a transmitter still busy with a previous
                // frame is allowed to hold us off indefinitely.
                if (!tx_busy) begin
                    tx_start_nxt = 1'b1;
                    to_cnt_nxt   = '0;
                    state_nxt    = S_WAIT_DONE;
                end
            end

            S_WAIT_DONE: begin
                to_cnt_nxt = to_cnt + 13'd1;
                if (tx_done) begin
                    // A completion arriving on the expiry cycle still counts
                    // as a good frame.
                    gap_cnt_nxt = '0;
                    state_nxt   = post_frame_state();
                end else if (to_cnt == TO_LAST) begin
                    err_nxt     = 1'b1;
                    gap_cnt_nxt = '0;
                    state_nxt   = post_frame_state();
                end
            end

            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + GAP_W'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and all outputs registered; reset drops any frame in flight.
    always_ff @(posedge clk_tx) begin
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            gnt          <= '0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            tx_d_num     <= 1'b0;
            tx_stop_bits <= 1'b0;
            active_id    <= '0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            to_cnt       <= to_cnt_nxt;
            gap_cnt      <= gap_cnt_nxt;
            gnt          <= gnt_nxt;
            tx_start     <= tx_start_nxt;
            tx_data      <= tx_data_nxt;
            tx_d_num     <= tx_d_num_nxt;
            tx_stop_bits <= tx_stop_nxt;
            active_id    <= active_id_nxt;
            err_timeout  <= err_nxt;
        end
    end

endmodule
